// File: rtl/wb_rr_arbiter_if.sv
// Wishbone bundle shared by the requesting masters, the round-robin arbiter and the crossbar port.
// The master modport is the surrounding system (requesters plus downstream slave); slave is the arbiter.
interface wb_rr_arbiter_if #(
    parameter int unsigned NM = 2,
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 128,
    parameter int unsigned SW = DW / 8
);
    logic [NM*AW-1:0] i_m_wb_adr;
    logic [NM*SW-1:0] i_m_wb_sel;
    logic [NM-1:0]    i_m_wb_we;
    logic [NM*DW-1:0] i_m_wb_dat;
    logic [NM-1:0]    i_m_wb_cyc;
    logic [NM-1:0]    i_m_wb_stb;
    logic [DW-1:0]    o_m_wb_dat;
    logic [NM-1:0]    o_m_wb_ack;
    logic [NM-1:0]    o_m_wb_err;

    logic [AW-1:0]    o_s_wb_adr;
    logic [SW-1:0]    o_s_wb_sel;
    logic             o_s_wb_we;
    logic [DW-1:0]    o_s_wb_dat;
    logic             o_s_wb_cyc;
    logic             o_s_wb_stb;
    logic [DW-1:0]    i_s_wb_dat;
    logic             i_s_wb_ack;
    logic             i_s_wb_err;

    modport master (
        output i_m_wb_adr, i_m_wb_sel, i_m_wb_we, i_m_wb_dat, i_m_wb_cyc, i_m_wb_stb,
        output i_s_wb_dat, i_s_wb_ack, i_s_wb_err,
        input  o_m_wb_dat, o_m_wb_ack, o_m_wb_err,
        input  o_s_wb_adr, o_s_wb_sel, o_s_wb_we, o_s_wb_dat, o_s_wb_cyc, o_s_wb_stb
    );

    modport slave (
        input  i_m_wb_adr, i_m_wb_sel, i_m_wb_we, i_m_wb_dat, i_m_wb_cyc, i_m_wb_stb,
        input  i_s_wb_dat, i_s_wb_ack, i_s_wb_err,
        output o_m_wb_dat, o_m_wb_ack, o_m_wb_err,
        output o_s_wb_adr, o_s_wb_sel, o_s_wb_we, o_s_wb_dat, o_s_wb_cyc, o_s_wb_stb
    );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: one granted master owns the downstream port for its whole cyc.
// Optional stall watchdog compiled in with WB_ARB_WATCHDOG_EN.
module wb_rr_arbiter #(
    parameter int unsigned NM     = 2,
    parameter int unsigned AW     = 32,
    parameter int unsigned DW     = 128,
    parameter int unsigned SW     = DW / 8,
    parameter int unsigned TO_CYC = 255
) (
    input  logic           clk,
    input  logic           rst,
    wb_rr_arbiter_if.slave bus,
    output logic [NM-1:0]  o_grant,
    output logic           o_timeout
);
    localparam int unsigned LW = (NM > 1) ? $clog2(NM) : 1;

    generate
        if (NM < 2 || NM > 8) begin : g_bad_nm
            $error("wb_rr_arbiter: NM out of range 2..8");
        end
        if (TO_CYC < 2 || TO_CYC > 65535) begin : g_bad_to
            $error("wb_rr_arbiter: TO_CYC out of range 2..65535");
        end
    endgenerate

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_q, state_d;
    logic [NM-1:0] grant_q, grant_d;
    logic [LW-1:0] last_q,  last_d;
    logic          win_found;
    logic [LW-1:0] win_idx;
    logic [LW-1:0] scan_idx;
    logic          own_cyc;
    logic          own_stb;
    logic          fire;

    // First requester after the previous winner; the previous winner itself is scanned last.
    always_comb begin : p_scan
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int unsigned i = 1; i <= NM; i++) begin
            scan_idx = LW'((32'(last_q) + i) % NM);
            if (!win_found && bus.i_m_wb_cyc[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    // last_q always holds the index of the current owner while BUSY.
    assign own_cyc = (state_q == BUSY) && bus.i_m_wb_cyc[last_q];
    assign own_stb = own_cyc && bus.i_m_wb_stb[last_q];

    always_ff @(posedge clk) begin : p_state
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= LW'(NM - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    always_comb begin : p_next
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = BUSY;
                    grant_d = NM'(1) << win_idx;
                    last_d  = win_idx;
                end
            end
            BUSY: begin
                // Owner released the bus: hand over on this same edge or fall back to idle.
                if (!own_cyc) begin
                    if (win_found) begin
                        grant_d = NM'(1) << win_idx;
                        last_d  = win_idx;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef WB_ARB_WATCHDOG_EN
    localparam int unsigned CW = $clog2(TO_CYC + 1);

    logic [CW-1:0] wd_cnt_q, wd_cnt_d;

    // A genuine response in the limit cycle wins over the timeout.
    assign fire = own_stb && !bus.i_s_wb_ack && !bus.i_s_wb_err && (wd_cnt_q == CW'(TO_CYC));

    always_comb begin : p_wd_next
        wd_cnt_d = '0;
        if (bus.o_s_wb_stb && !bus.i_s_wb_ack && !bus.i_s_wb_err) begin
            wd_cnt_d = wd_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin : p_wd
        if (rst) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end
`else
    assign fire = 1'b0;
`endif

    assign bus.o_s_wb_adr = bus.i_m_wb_adr[32'(last_q) * AW +: AW];
    assign bus.o_s_wb_sel = bus.i_m_wb_sel[32'(last_q) * SW +: SW];
    assign bus.o_s_wb_dat = bus.i_m_wb_dat[32'(last_q) * DW +: DW];
    assign bus.o_s_wb_we  = bus.i_m_wb_we[last_q];
    assign bus.o_s_wb_cyc = own_cyc;
    assign bus.o_s_wb_stb = own_stb && !fire;

    assign bus.o_m_wb_dat = bus.i_s_wb_dat;
    assign bus.o_m_wb_ack = grant_q & {NM{bus.i_s_wb_ack}};
    assign bus.o_m_wb_err = grant_q & {NM{bus.i_s_wb_err || fire}};

    assign o_grant   = grant_q;
    assign o_timeout = fire;
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: behavioural arbiter model compared every cycle, plus directed literal checks.
module tb_wb_rr_arbiter;
    localparam int unsigned NM = 2;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 128;
    localparam int unsigned SW = DW / 8;
    localparam int unsigned TO = 4;
`ifdef WB_ARB_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NM-1:0] o_grant;
    logic          o_timeout;

    wb_rr_arbiter_if #(.NM(NM), .AW(AW), .DW(DW), .SW(SW)) bus ();

    wb_rr_arbiter #(.NM(NM), .AW(AW), .DW(DW), .SW(SW), .TO_CYC(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .o_grant   (o_grant),
        .o_timeout (o_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Requester / slave agent state, set by the stimulus and applied just after each rising edge.
    int      rem    [NM];
    int      bursts [NM];
    int      xfers  [NM];
    int      cnt    [NM];
    bit      we_m   [NM];
    int      slave_mode = 0;   // 0 ack, 1 err, 2 never respond
    logic [NM-1:0] done;
    logic    stb_seen;
    logic    resp_prev;
    int      cyc_no;

    initial begin : agent
        bus.i_m_wb_adr = '0; bus.i_m_wb_sel = '0; bus.i_m_wb_we  = '0;
        bus.i_m_wb_dat = '0; bus.i_m_wb_cyc = '0; bus.i_m_wb_stb = '0;
        bus.i_s_wb_dat = '0; bus.i_s_wb_ack = 1'b0; bus.i_s_wb_err = 1'b0;
        resp_prev = 1'b0;
        cyc_no    = 0;
        for (int k = 0; k < NM; k++) begin
            rem[k] = 0; bursts[k] = 0; xfers[k] = 0; cnt[k] = 0; we_m[k] = 1'b0;
        end
        forever begin
            @(negedge clk);
            done     = bus.o_m_wb_ack | bus.o_m_wb_err;
            stb_seen = bus.o_s_wb_stb;
            @(posedge clk);
            #1;
            // Slave answers one cycle after it sees a strobe, never on two cycles back to back.
            bus.i_s_wb_ack = (slave_mode == 0) && stb_seen && !resp_prev;
            bus.i_s_wb_err = (slave_mode == 1) && stb_seen && !resp_prev;
            resp_prev      = bus.i_s_wb_ack | bus.i_s_wb_err;
            cyc_no++;
            bus.i_s_wb_dat = {4{32'hC0DE_0000 + 32'(cyc_no)}};
            for (int k = 0; k < NM; k++) begin
                if (done[k] && rem[k] > 0) begin
                    rem[k]--;
                    cnt[k]++;
                end
                if (rem[k] == 0 && bursts[k] > 0 && !bus.i_m_wb_cyc[k]) begin
                    bursts[k]--;
                    rem[k] = xfers[k];
                end
                bus.i_m_wb_cyc[k]          = (rem[k] > 0);
                bus.i_m_wb_stb[k]          = (rem[k] > 0);
                bus.i_m_wb_we[k]           = we_m[k];
                bus.i_m_wb_adr[k*AW +: AW] = 32'h0100_0000 + (32'(k) << 20) + 32'(cnt[k]) * 32'd16;
                bus.i_m_wb_dat[k*DW +: DW] = {4{32'hA5A5_0000 + 32'(k * 256 + cnt[k])}};
                bus.i_m_wb_sel[k*SW +: SW] = we_m[k] ? {SW{1'b1}} : {{(SW/2){1'b0}}, {(SW/2){1'b1}}};
            end
        end
    end

    // Reference model: owner index, previous winner and stall count as plain integers.
    bit m_busy = 1'b0;
    int m_own  = 0;
    int m_last = NM - 1;
    int m_wd   = 0;

    function automatic int pick(input logic [NM-1:0] req, input int after);
        for (int d = 1; d <= NM; d++) begin
            if (req[(after + d) % NM]) return (after + d) % NM;
        end
        return -1;
    endfunction

    function automatic bit exp_fire();
        return WD_EN && m_busy && bus.i_m_wb_cyc[m_own] && bus.i_m_wb_stb[m_own]
               && !bus.i_s_wb_ack && !bus.i_s_wb_err && (m_wd == int'(TO));
    endfunction

    function automatic bit exp_cyc();
        return m_busy && bus.i_m_wb_cyc[m_own];
    endfunction

    function automatic bit exp_stb();
        return exp_cyc() && bus.i_m_wb_stb[m_own] && !exp_fire();
    endfunction

    function automatic logic [NM-1:0] exp_grant();
        return m_busy ? (NM'(1) << m_own) : '0;
    endfunction

    always @(posedge clk) begin : model
        if (rst) begin
            m_busy <= 1'b0;
            m_last <= NM - 1;
            m_wd   <= 0;
        end else begin
            if (!exp_cyc()) begin
                if (pick(bus.i_m_wb_cyc, m_last) >= 0) begin
                    m_busy <= 1'b1;
                    m_own  <= pick(bus.i_m_wb_cyc, m_last);
                    m_last <= pick(bus.i_m_wb_cyc, m_last);
                end else begin
                    m_busy <= 1'b0;
                end
            end
            m_wd <= (exp_stb() && !bus.i_s_wb_ack && !bus.i_s_wb_err) ? m_wd + 1 : 0;
        end
    end

    bit cmp_en = 1'b0;

    always @(negedge clk) begin : compare
        if (cmp_en) begin
            chk("m_grant",   DW'(o_grant),          DW'(exp_grant()));
            chk("m_s_cyc",   DW'(bus.o_s_wb_cyc),   DW'(exp_cyc()));
            chk("m_s_stb",   DW'(bus.o_s_wb_stb),   DW'(exp_stb()));
            chk("m_ack",     DW'(bus.o_m_wb_ack),   DW'(exp_grant() & {NM{bus.i_s_wb_ack}}));
            chk("m_err",     DW'(bus.o_m_wb_err),   DW'(exp_grant() & {NM{bus.i_s_wb_err | exp_fire()}}));
            chk("m_timeout", DW'(o_timeout),        DW'(exp_fire()));
            chk("m_rdat",    bus.o_m_wb_dat,        bus.i_s_wb_dat);
            if (exp_cyc()) begin
                chk("m_s_adr", DW'(bus.o_s_wb_adr), DW'(bus.i_m_wb_adr[m_own*AW +: AW]));
                chk("m_s_sel", DW'(bus.o_s_wb_sel), DW'(bus.i_m_wb_sel[m_own*SW +: SW]));
                chk("m_s_we",  DW'(bus.o_s_wb_we),  DW'(bus.i_m_wb_we[m_own]));
                chk("m_s_dat", bus.o_s_wb_dat,      bus.i_m_wb_dat[m_own*DW +: DW]);
            end
        end
    end

    // Record each new owner and count watchdog pulses.
    int            glog[$];
    logic [NM-1:0] prev_g = '0;
    int            to_cnt = 0;

    always @(negedge clk) begin : monitor
        if (o_grant != prev_g && o_grant != '0) begin
            for (int k = 0; k < NM; k++) if (o_grant[k]) glog.push_back(k);
        end
        prev_g <= o_grant;
        to_cnt <= to_cnt + int'(o_timeout);
    end

    task automatic launch(input int k, input int nb, input int nx, input bit w);
        we_m[k]   = w;
        xfers[k]  = nx;
        bursts[k] = nb;
    endtask

    function automatic bit agents_busy();
        for (int k = 0; k < NM; k++) if (rem[k] > 0 || bursts[k] > 0) return 1'b1;
        return (bus.i_m_wb_cyc != '0);
    endfunction

    task automatic wait_idle(input string name, input int max);
        int n;
        n = 0;
        while ((agents_busy() || o_grant != '0) && n < max) begin
            @(negedge clk);
            n++;
        end
        chk(name, DW'(n < max), DW'(1'b1));
    endtask

    initial begin : stim
        int to0;
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        chk("rst_grant",   DW'(o_grant),        DW'(2'b00));
        chk("rst_s_cyc",   DW'(bus.o_s_wb_cyc), DW'(1'b0));
        chk("rst_s_stb",   DW'(bus.o_s_wb_stb), DW'(1'b0));
        chk("rst_ack",     DW'(bus.o_m_wb_ack), DW'(2'b00));
        chk("rst_timeout", DW'(o_timeout),      DW'(1'b0));

        // Single write from master 0.
        rst = 1'b0;
        launch(0, 1, 1, 1'b1);
        @(negedge clk);
        chk("wr_grant_lat", DW'(o_grant), DW'(2'b00));
        @(negedge clk);
        chk("wr_grant",  DW'(o_grant),        DW'(2'b01));
        chk("wr_s_cyc",  DW'(bus.o_s_wb_cyc), DW'(1'b1));
        chk("wr_adr",    DW'(bus.o_s_wb_adr), DW'(32'h0100_0000));
        chk("wr_we",     DW'(bus.o_s_wb_we),  DW'(1'b1));
        @(negedge clk);
        chk("wr_ack",    DW'(bus.o_m_wb_ack), DW'(2'b01));
        wait_idle("wr_drain", 20);

        // Slave error on master 1 read.
        slave_mode = 1;
        launch(1, 1, 1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("err_grant", DW'(o_grant),        DW'(2'b10));
        chk("err_adr",   DW'(bus.o_s_wb_adr), DW'(32'h0110_0000));
        @(negedge clk);
        chk("err_route", DW'(bus.o_m_wb_err), DW'(2'b10));
        chk("err_noack", DW'(bus.o_m_wb_ack), DW'(2'b00));
        wait_idle("err_drain", 20);
        slave_mode = 0;

        // Simultaneous requests, three transfers each.
        glog.delete();
        launch(0, 1, 3, 1'b1);
        launch(1, 1, 3, 1'b0);
        wait_idle("sim_drain", 60);
        chk("sim_n",     DW'(glog.size()), DW'(2));
        chk("sim_first", DW'(glog[0]),     DW'(0));
        chk("sim_second",DW'(glog[1]),     DW'(1));

        // Both re-request every time: strict alternation over 8 rounds each.
        glog.delete();
        launch(0, 8, 1, 1'b0);
        launch(1, 8, 1, 1'b1);
        wait_idle("alt_drain", 200);
        chk("alt_n", DW'(glog.size()), DW'(16));
        for (int i = 0; i < glog.size(); i++) chk($sformatf("alt_%0d", i), DW'(glog[i]), DW'(i % 2));

        // Slave never responds.
        slave_mode = 2;
        to0 = to_cnt;
        launch(0, 1, 1, 1'b1);
`ifdef WB_ARB_WATCHDOG_EN
        repeat (5) @(negedge clk);
        chk("wd_pre_to",  DW'(o_timeout),        DW'(1'b0));
        chk("wd_pre_stb", DW'(bus.o_s_wb_stb),   DW'(1'b1));
        @(negedge clk);
        chk("wd_to",      DW'(o_timeout),        DW'(1'b1));
        chk("wd_err",     DW'(bus.o_m_wb_err),   DW'(2'b01));
        chk("wd_stb_low", DW'(bus.o_s_wb_stb),   DW'(1'b0));
        wait_idle("wd_drain", 20);
        chk("wd_pulses",  DW'(to_cnt - to0),     DW'(1));
`else
        repeat (1002) @(negedge clk);
        chk("hang_grant", DW'(o_grant),          DW'(2'b01));
        chk("hang_stb",   DW'(bus.o_s_wb_stb),   DW'(1'b1));
        chk("hang_pulses",DW'(to_cnt - to0),     DW'(0));
        rem[0] = 0;
        wait_idle("hang_drain", 20);
`endif

        // Reset in the middle of a master 1 transfer.
        launch(1, 1, 1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("rm_grant", DW'(o_grant), DW'(2'b10));
        rst = 1'b1;
        launch(0, 1, 1, 1'b1);
        @(negedge clk);
        chk("rm_drop",  DW'(o_grant), DW'(2'b00));
        @(negedge clk);
        slave_mode = 0;
        rst = 1'b0;
        @(negedge clk);
        chk("rm_after", DW'(o_grant), DW'(2'b01));
        wait_idle("rm_drain", 40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : guard
        #100000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "bench time limit");
    end
endmodule
